// File: rtl/mem_arbiter.sv
// Single-port memory responder: serialises instruction and data requests onto
// one synchronous RAM port, data first, releasing each wait line for one cycle.
module mem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          src_d, src_d_n;
  logic          wr_q, wr_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] store_q, store_n;

  logic          iwait_n, dwait_n, ramREN_n, ramWEN_n;
  logic [DW-1:0] iload_n, dload_n, ramaddr_n, ramstore_n;
  logic          req_active;

  // Word addresses only; the byte-offset bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  assign req_active = src_d ? (dREN | dWEN) : iREN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      src_d    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      src_d    <= src_d_n;
      wr_q     <= wr_n;
      addr_q   <= addr_n;
      store_q  <= store_n;
      iwait    <= iwait_n;
      dwait    <= dwait_n;
      iload    <= iload_n;
      dload    <= dload_n;
      ramREN   <= ramREN_n;
      ramWEN   <= ramWEN_n;
      ramaddr  <= ramaddr_n;
      ramstore <= ramstore_n;
    end
  end

  // Next state, latched request and next registered outputs.
  always_comb begin
    state_n    = state;
    count_n    = count;
    src_d_n    = src_d;
    wr_n       = wr_q;
    addr_n     = addr_q;
    store_n    = store_q;
    iwait_n    = 1'b1;
    dwait_n    = 1'b1;
    iload_n    = '0;
    dload_n    = '0;
    ramREN_n   = 1'b0;
    ramWEN_n   = 1'b0;
    ramaddr_n  = '0;
    ramstore_n = '0;

    unique case (state)
      IDLE: begin
        if (dWEN | dREN) begin
          state_n = BUSY;
          count_n = '0;
          src_d_n = 1'b1;
          wr_n    = dWEN;
          addr_n  = daddr[31:2];
          store_n = dstore;
        end else if (iREN) begin
          state_n = BUSY;
          count_n = '0;
          src_d_n = 1'b0;
          wr_n    = 1'b0;
          addr_n  = iaddr[31:2];
        end
      end
      BUSY: begin
        // A withdrawn request aborts even on the final access cycle.
        if (!req_active) begin
          state_n = IDLE;
        end else if (count == LAST) begin
          state_n = DONE;
          if (src_d) begin
            dwait_n = 1'b0;
            dload_n = wr_q ? '0 : ramload;
          end else begin
            iwait_n = 1'b0;
            iload_n = ramload;
          end
        end else begin
          count_n = CW'(count + CW'(1));
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == BUSY) begin
      ramREN_n   = ~wr_n;
      ramWEN_n   = wr_n;
      ramaddr_n  = {addr_n, 2'b00};
      ramstore_n = store_n;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory responder on the cache side of the memory hierarchy. It accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the cache level and serialises them onto one synchronous RAM port. It holds each requester's wait line high until the access completes, then releases it for exactly one cycle with the load data valid. Data requests take priority over instruction fetches.

## Interface
- LAT, default 2: RAM access time in cycles (BUSY cycles per access); legal range 2..15.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait observed low.
- iaddr  in  32  instruction word address; bits [1:0] ignored.
- iwait  out  1  low for exactly the completion cycle of an instruction access, high otherwise.
- iload  out  32  instruction word; valid only while iwait low, else 0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both high.
- daddr  in  32  data word address; bits [1:0] ignored.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completion cycle of a data access, high otherwise.
- dload  out  32  read data; valid only while dwait low on a read, else 0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM word address (bits [1:0] forced 0).
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid one cycle after address is first presented and stable while address/ramREN hold.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if dWEN|dREN, latch op (write if dWEN), source=D, address (daddr[31:2]), dstore; else if iREN, latch read, source=I, iaddr[31:2]; go BUSY with count=0. Otherwise stay.
- BUSY: drive ramREN/ramWEN, ramaddr, ramstore from latched values; count increments each cycle. In the cycle count==LAT-1, capture ramload into the load register (reads) and go DONE.
- Abort: if the latched source's request line (iREN for I; dREN|dWEN for D) is low during any BUSY cycle, go IDLE next cycle; no wait released, load register unchanged, RAM strobes drop.
- DONE: lower the wait line of the latched source; drive the captured word on iload or dload (dload stays 0 for writes). RAM strobes low. Unconditionally go IDLE.
- Arbitration is decided only in IDLE; a pending iREN loses to a simultaneous data request and is served on the next IDLE. No preemption of an accepted access.
- Requester address/data changes after acceptance are ignored (latched copies used).
- Reset: state IDLE, count 0, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, latches and load register cleared.

## Timing
- Request high in cycle 0 (IDLE) -> BUSY cycles 1..LAT -> DONE in cycle LAT+1 (wait low) -> IDLE in cycle LAT+2.
- Back-to-back: new request sampled in the IDLE cycle LAT+2; minimum access spacing LAT+2 cycles.
- Wait lines are registered outputs; never both low in the same cycle; wait low lasts exactly one cycle.
- iload/dload are registered and valid together with the corresponding wait-low cycle.
- RST asserted in any state: all outputs take reset values on the next edge; an in-flight access is dropped with no completion.
- Count width 4 bits; no wrap possible within legal LAT.

## Test plan
- Reset: hold RST 2 cycles with iREN=1 -> iwait=1, dwait=1, iload=0, ramREN=0 throughout; first access starts after RST drops.
- Instruction fetch, LAT=2: iREN=1, iaddr=0x0000_0044, RAM model word 0x2001_0005 -> ramREN=1, ramaddr=0x44 for cycles 1-2; iwait=0, iload=0x2001_0005 only in cycle 3; iwait=1 in cycle 4.
- Priority: iREN=1 and dREN=1 (daddr=0x100, RAM 0xDEAD_BEEF) in same cycle -> dwait low cycle 3 with dload=0xDEAD_BEEF; ramaddr switches to iaddr in cycle 5; iwait low in cycle 7.
- Write: dWEN=1, dREN=1, daddr=0x204, dstore=0x1234_5678 -> ramWEN=1, ramREN=0, ramstore=0x1234_5678 for LAT cycles; dwait low one cycle, dload=0; RAM model then holds 0x1234_5678 at 0x204.
- Abort: LAT=4, iREN dropped in BUSY cycle 2 -> ramREN low and state IDLE next cycle, iwait never low, iload stays 0.
- Reset mid-access: RST pulsed in BUSY cycle 1 -> no wait-low pulse, outputs at reset values the next cycle, fresh request completes normally afterward.
